spi_slave_responder: RTL and testbench
======================================

SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port SCK  input  1  SPI serial clock from the master; asynchronous to CLK.
REQ-004 SHALL have port CS  input  1  SPI chip select, active low; asynchronous to CLK.
REQ-005 SHALL have port MOSI  input  1  serial data from the master.
REQ-006 SHALL have port MISO  output  1  serial data to the master.
REQ-007 SHALL have port spi_mode_in  input  2  {CPOL,CPHA}.
REQ-008 SHALL have port word_len_in  input  2  00=8, 01=16, 10=24, 11=32 bits.
REQ-009 SHALL have port miso_data_in  input  32  word to transmit, MSB-first from bit (len-1).
REQ-010 SHALL have port busy_out  output  1  high while a frame is active.
REQ-011 SHALL have port mosi_data_out  output  32  last received word, right-aligned, upper bits zero.
REQ-012 SHALL have port mosi_valid_out  output  1  one-CLK pulse when mosi_data_out updates.

Function
REQ-013 SHALL pass SCK, CS and MOSI through 2-flop synchronizers and detect edges on the synchronized signals; SCK frequency SHALL be at most CLK/8.
REQ-014 SHALL implement states IDLE and SHIFT; IDLE->SHIFT on synchronized CS falling edge, SHIFT->IDLE on synchronized CS rising edge.
REQ-015 SHALL latch spi_mode_in, word_len_in and miso_data_in on the IDLE->SHIFT transition; changes during SHIFT SHALL be ignored.
REQ-016 Leading edge SHALL be SCK rising when CPOL=0, falling when CPOL=1; trailing edge is the opposite.
REQ-017 CPHA=0: MOSI SHALL be sampled on the leading edge; MISO SHALL present the first bit within 1 CLK of entering SHIFT and advance on each trailing edge.
REQ-018 CPHA=1: MISO SHALL advance on each leading edge (first leading edge presents the first bit); MOSI SHALL be sampled on the trailing edge.
REQ-019 A 6-bit bit counter SHALL count samples; on the len-th sample mosi_data_out SHALL update and mosi_valid_out SHALL pulse exactly 1 CLK later, then the counter SHALL wrap to 0.
REQ-020 If CS stays low after a completed word, miso_data_in SHALL be re-latched at the word boundary and the next word SHALL continue without gaps.
REQ-021 busy_out SHALL be high in SHIFT and low in IDLE; MISO SHALL be driven 0 in IDLE.
REQ-022 CS rising with a partial word SHALL discard the partial bits; mosi_data_out SHALL keep its previous value and no valid pulse SHALL occur.
REQ-023 SCK edges while in IDLE SHALL be ignored.

Reset
REQ-024 RST high SHALL asynchronously force IDLE, counter 0, MISO=0, busy_out=0, mosi_data_out=0, mosi_valid_out=0, synchronizer flops to idle levels (CS=1, SCK=0, MOSI=0).
REQ-025 After RST release with CS already low, the block SHALL remain in IDLE until CS has been seen high then low.
REQ-026 RST mid-frame SHALL abort the frame with no valid pulse.

Configuration
REQ-027 With macro SPI_SLAVE_FRAME_ERR_EN defined, an output frame_err_out (1 bit, reset 0) SHALL pulse for 1 CLK when CS rises with a nonzero bit counter.
REQ-028 Without SPI_SLAVE_FRAME_ERR_EN, frame_err_out SHALL not exist and partial frames SHALL be discarded silently per REQ-022.

Verification
REQ-029 Mode 0, len 8, master sends 0xA5, miso_data_in=0x3C -> mosi_data_out=0x000000A5 with one valid pulse; master receives 0x3C.
REQ-030 Mode 3, len 32, MOSI 0xDEADBEEF, miso_data_in=0x12345678 -> mosi_data_out=0xDEADBEEF; master receives 0x12345678.
REQ-031 Mode 1, len 16, two back-to-back words 0x1234, 0xABCD in one CS window, miso_data_in changed to 0x5555 mid-first word -> two valid pulses, values 0x1234 then 0xABCD; master receives the first-latched word then 0x5555.
REQ-032 Mode 2, len 24, CS rises after 10 bits -> no valid pulse, mosi_data_out unchanged, busy_out low within 3 CLK; with SPI_SLAVE_FRAME_ERR_EN one frame_err_out pulse.
REQ-033 RST asserted after 5 bits of a mode 0 len 8 frame, released with CS low -> all outputs 0, next SCK edges ignored until CS toggles high then low.

Source files
------------

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI slave, modes 0-3, 8/16/24/32-bit words, CLK-domain oversampling.
// Define SPI_SLAVE_FRAME_ERR_EN to add frame_err_out for frames cut short by CS.
module spi_slave_responder (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [1:0]  spi_mode_in,
    input  logic [1:0]  word_len_in,
    input  logic [31:0] miso_data_in,
    output logic        busy_out,
    output logic [31:0] mosi_data_out,
    output logic        mosi_valid_out
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic        frame_err_out
`endif
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;
    logic [2:0]  cs_q, sck_q;
    logic [1:0]  mosi_q, settle;
    logic        armed, cpol, cpha, done, miso_r;
    logic [1:0]  len_r;
    logic [31:0] tx, rx, first_word, reload_word, mask;
    logic [5:0]  cnt, nbits;
    logic        cs_fall, cs_rise, sck_rise, sck_fall, start, active;
    logic        lead, trail, sample, advance, last;

    function automatic logic [31:0] align(input logic [31:0] w, input logic [1:0] l);
        return l == 2'd0 ? {w[7:0], 24'd0} : l == 2'd1 ? {w[15:0], 16'd0} :
               l == 2'd2 ? {w[23:0], 8'd0} : w;
    endfunction

    // settle keeps reset-time synchronizer levels from arming a frame while CS is already low
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cs_q   <= 3'b111;
            sck_q  <= 3'b000;
            mosi_q <= 2'b00;
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            cs_q   <= {cs_q[1:0], CS};
            sck_q  <= {sck_q[1:0], SCK};
            mosi_q <= {mosi_q[0], MOSI};
            settle <= {settle[0], 1'b1};
            armed  <= armed | (settle[1] & cs_q[1]);
        end
    end

    assign cs_fall     = cs_q[2] & ~cs_q[1];
    assign cs_rise     = ~cs_q[2] & cs_q[1];
    assign sck_rise    = sck_q[1] & ~sck_q[2];
    assign sck_fall    = ~sck_q[1] & sck_q[2];
    assign start       = (state == IDLE) & cs_fall & armed;
    assign active      = (state == SHIFT) & ~cs_rise;
    assign lead        = active & (cpol ? sck_fall : sck_rise);
    assign trail       = active & (cpol ? sck_rise : sck_fall);
    assign sample      = cpha ? trail : lead;
    assign advance     = cpha ? lead : trail;
    assign nbits       = {1'b0, len_r, 3'b000} + 6'd8;
    assign last        = sample & (cnt == nbits - 6'd1);
    assign first_word  = align(miso_data_in, word_len_in);
    assign reload_word = align(miso_data_in, len_r);
    assign mask        = {{8{len_r == 2'd3}}, {8{len_r[1]}}, {8{len_r != 2'd0}}, 8'hFF};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE) ? (start ? SHIFT : IDLE) : (cs_rise ? IDLE : SHIFT);
    end

    always_comb begin
        busy_out = (state == SHIFT);
        MISO     = miso_r;
    end

    // tx holds the bits still to be presented, MSB-aligned; sample and advance never coincide
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpol           <= 1'b0;
            cpha           <= 1'b0;
            len_r          <= 2'd0;
            tx             <= 32'd0;
            rx             <= 32'd0;
            cnt            <= 6'd0;
            done           <= 1'b0;
            miso_r         <= 1'b0;
            mosi_data_out  <= 32'd0;
            mosi_valid_out <= 1'b0;
        end else begin
            done           <= last;
            mosi_valid_out <= done;
            if (done) mosi_data_out <= rx & mask;
            if (start) begin
                {cpol, cpha} <= spi_mode_in;
                len_r        <= word_len_in;
                tx           <= spi_mode_in[0] ? first_word : first_word << 1;
                miso_r       <= spi_mode_in[0] ? 1'b0 : first_word[31];
                cnt          <= 6'd0;
                rx           <= 32'd0;
            end else if ((state == SHIFT) && cs_rise) begin
                cnt    <= 6'd0;
                miso_r <= 1'b0;
            end else begin
                if (sample) begin
                    rx  <= {rx[30:0], mosi_q[1]};
                    cnt <= last ? 6'd0 : cnt + 6'd1;
                end
                if (last) tx <= reload_word;
                else if (advance) begin
                    miso_r <= tx[31];
                    tx     <= tx << 1;
                end
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) frame_err_out <= 1'b0;
        else frame_err_out <= (state == SHIFT) && cs_rise && (cnt != 6'd0);
    end
`endif
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: bit-banged SPI master with a scoreboard of expected received words.
module tb_spi_slave_responder;
    localparam int HALF = 80;
    logic        clk, rst, sck, cs, mosi, miso, busy, valid;
    logic [1:0]  mode, len;
    logic [31:0] miso_data, data;
    logic [31:0] exp_q[$];
    int          tests, fails, vcount, ferr_cnt;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_err;
`endif

    spi_slave_responder dut (
        .CLK(clk), .RST(rst), .SCK(sck), .CS(cs), .MOSI(mosi), .MISO(miso),
        .spi_mode_in(mode), .word_len_in(len), .miso_data_in(miso_data),
        .busy_out(busy), .mosi_data_out(data), .mosi_valid_out(valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err_out(frame_err)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (valid) begin
            vcount++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL valid_unexpected: got data %h, no word expected", data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    fails++;
                    $display("FAIL rx_word: got %h expected %h", data, e);
                end
            end
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err) ferr_cnt++;
`endif
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cs_low(input logic [1:0] m, input logic [1:0] l, input logic [31:0] d);
        @(negedge clk);
        mode = m;
        len = l;
        miso_data = d;
        sck = m[1];
        repeat (4) @(negedge clk);
        cs = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic cs_high;
        #HALF;
        cs = 1;
        repeat (10) @(negedge clk);
    endtask

    task automatic xfer_word(input int nbits, input logic [31:0] txw, output logic [31:0] rxw,
                             input int change_at, input logic [31:0] new_miso);
        rxw = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i == change_at) miso_data = new_miso;
            if (!mode[0]) begin
                mosi = txw[nbits-1-i];
                #HALF;
                rxw = {rxw[30:0], miso};
                sck = ~sck;
                #HALF;
                sck = ~sck;
            end else begin
                sck = ~sck;
                mosi = txw[nbits-1-i];
                #HALF;
                rxw = {rxw[30:0], miso};
                sck = ~sck;
                #HALF;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1; cs = 1; sck = 0; mosi = 0; mode = 0; len = 0; miso_data = 0;
        repeat (3) @(negedge clk);
        tests += 4;
        if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b expected 0", miso); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (data !== 32'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", data); end
        if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
        rst = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_mode0;
        logic [31:0] r;
        cs_low(2'd0, 2'd0, 32'h3C);
        exp_q.push_back(32'hA5);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL m0_busy_hi: got %b expected 1", busy); end
        xfer_word(8, 32'hA5, r, -1, 0);
        tests++;
        if (r !== 32'h3C) begin fails++; $display("FAIL m0_master_rx: got %h expected 3c", r); end
        cs_high;
        tests += 3;
        if (busy !== 1'b0) begin fails++; $display("FAIL m0_busy_lo: got %b expected 0", busy); end
        if (exp_q.size() != 0) begin fails++; $display("FAIL m0_missing_valid: %0d words pending, expected 0", exp_q.size()); end
        if (data !== 32'hA5) begin fails++; $display("FAIL m0_data: got %h expected a5", data); end
    endtask

    task automatic test_mode3;
        logic [31:0] r;
        cs_low(2'd3, 2'd3, 32'h12345678);
        exp_q.push_back(32'hDEADBEEF);
        xfer_word(32, 32'hDEADBEEF, r, -1, 0);
        cs_high;
        tests += 3;
        if (r !== 32'h12345678) begin fails++; $display("FAIL m3_master_rx: got %h expected 12345678", r); end
        if (exp_q.size() != 0) begin fails++; $display("FAIL m3_missing_valid: %0d pending, expected 0", exp_q.size()); end
        if (data !== 32'hDEADBEEF) begin fails++; $display("FAIL m3_data: got %h expected deadbeef", data); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r0, r1;
        int v0;
        v0 = vcount;
        cs_low(2'd1, 2'd1, 32'hBEEF);
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'hABCD);
        xfer_word(16, 32'h1234, r0, 5, 32'h5555);
        xfer_word(16, 32'hABCD, r1, -1, 0);
        cs_high;
        tests += 4;
        if (r0 !== 32'hBEEF) begin fails++; $display("FAIL b2b_rx0: got %h expected beef", r0); end
        if (r1 !== 32'h5555) begin fails++; $display("FAIL b2b_rx1: got %h expected 5555", r1); end
        if (vcount - v0 != 2) begin fails++; $display("FAIL b2b_pulses: got %0d expected 2", vcount - v0); end
        if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_missing_valid: %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_partial;
        logic [31:0] r, prev;
        int v0, f0;
        prev = data;
        v0 = vcount;
        f0 = ferr_cnt;
        cs_low(2'd2, 2'd2, 32'h0F0F0F);
        xfer_word(10, 32'h2AB, r, -1, 0);
        #HALF;
        cs = 1;
        repeat (3) @(posedge clk);
        #1;
        tests += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL partial_busy: got %b expected 0 within 3 clk", busy); end
        if (r !== (32'h0F0F0F >> 14)) begin fails++; $display("FAIL partial_master_rx: got %h expected %h", r, 32'h0F0F0F >> 14); end
        repeat (20) @(negedge clk);
        tests += 2;
        if (vcount != v0) begin fails++; $display("FAIL partial_pulse: got %0d pulses expected 0", vcount - v0); end
        if (data !== prev) begin fails++; $display("FAIL partial_data: got %h expected %h", data, prev); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        tests++;
        if (ferr_cnt - f0 != 1) begin fails++; $display("FAIL partial_frame_err: got %0d pulses expected 1", ferr_cnt - f0); end
`endif
    endtask

    task automatic test_reset_midframe;
        logic [31:0] r;
        int v0, busy_seen;
        cs_low(2'd0, 2'd0, 32'h99);
        xfer_word(5, 32'h15, r, -1, 0);
        rst = 1;
        #1;
        tests += 4;
        if (miso !== 1'b0) begin fails++; $display("FAIL rstmid_miso: got %b expected 0", miso); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        if (data !== 32'd0) begin fails++; $display("FAIL rstmid_data: got %h expected 0", data); end
        if (valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
        repeat (3) @(negedge clk);
        rst = 0;
        v0 = vcount;
        busy_seen = 0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            mosi = i[0];
            sck = ~sck;
            #HALF;
            if (busy !== 1'b0 || miso !== 1'b0) busy_seen++;
        end
        tests += 2;
        if (busy_seen != 0) begin fails++; $display("FAIL rstmid_idle_ignored: got %0d active samples expected 0", busy_seen); end
        if (vcount != v0) begin fails++; $display("FAIL rstmid_pulse: got %0d pulses expected 0", vcount - v0); end
        cs_high;
        cs_low(2'd0, 2'd0, 32'h81);
        exp_q.push_back(32'h5A);
        xfer_word(8, 32'h5A, r, -1, 0);
        cs_high;
        tests += 3;
        if (r !== 32'h81) begin fails++; $display("FAIL rstmid_master_rx: got %h expected 81", r); end
        if (exp_q.size() != 0) begin fails++; $display("FAIL rstmid_missing_valid: %0d pending, expected 0", exp_q.size()); end
        if (data !== 32'h5A) begin fails++; $display("FAIL rstmid_data2: got %h expected 5a", data); end
    endtask

    initial begin
        tests = 0; fails = 0; vcount = 0; ferr_cnt = 0;
        test_reset;
        test_mode0;
        test_mode3;
        test_back_to_back;
        test_partial;
        test_reset_midframe;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
